// File: rtl/id_stage_p.sv
// id_stage_p: MIPS decode stage with bypassing register file, ID-resolved branches/jumps
// and the ID/EX pipeline register. Optional macro ID_SHIFT_EN enables SLL/SRL decode.
module id_stage_p #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned HALT_CNT = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             instr_d,
  input  logic [XLEN-1:0]         pc_plus4_d,
  input  logic                    stall_d,
  input  logic                    flush_e,
  input  logic                    fwd_a_d,
  input  logic                    fwd_b_d,
  input  logic [XLEN-1:0]         alu_out_m,
  input  logic                    reg_write_w,
  input  logic [$clog2(NREG)-1:0] write_reg_w,
  input  logic [XLEN-1:0]         result_w,
  output logic                    pc_src_d,
  output logic [XLEN-1:0]         pc_branch_d,
  output logic                    reg_write_e,
  output logic                    mem_to_reg_e,
  output logic                    mem_write_e,
  output logic                    alu_src_e,
  output logic                    reg_dst_e,
  output logic                    link_e,
  output logic [2:0]              alu_ctrl_e,
  output logic [$clog2(NREG)-1:0] rs_e,
  output logic [$clog2(NREG)-1:0] rt_e,
  output logic [$clog2(NREG)-1:0] rd_e,
  output logic [4:0]              shamt_e,
  output logic [XLEN-1:0]         rd1_e,
  output logic [XLEN-1:0]         rd2_e,
  output logic [XLEN-1:0]         imm_e,
  output logic [XLEN-1:0]         pc_plus4_e,
  output logic                    illegal_e,
  output logic                    halt_o
);
  localparam int unsigned RAW = $clog2(NREG);
  localparam int unsigned HCW = $clog2(HALT_CNT + 1);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_ADDI  = 6'h08, OP_LW  = 6'h23, OP_SW  = 6'h2B
  } opcode_e;
  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
    FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A
  } funct_e;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_SLL = 3'b100,
    ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_e;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_dst;
    logic            link;
    logic [2:0]      alu_ctrl;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
    logic            illegal;
  } ex_t;

  logic [XLEN-1:0] rf_q [NREG];
  ex_t             dec, ex_d, ex_q;
  logic [HCW-1:0]  hcnt_q, hcnt_d;
  logic            halt_q, halt_d;
  logic [RAW-1:0]  rs, rt;
  logic [XLEN-1:0] rd1, rd2, imm, op_a, op_b;
  logic            illegal, nop, is_beq, is_bne, is_jal, is_jr;

  assign rs  = RAW'(instr_d[25:21]);
  assign rt  = RAW'(instr_d[20:16]);
  assign imm = {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};

  // Write-through read: a same-cycle writeback to the addressed register wins, r0 stays 0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != '0) rd1 = (reg_write_w && write_reg_w == rs) ? result_w : rf_q[rs];
    if (rt != '0) rd2 = (reg_write_w && write_reg_w == rt) ? result_w : rf_q[rt];
  end

  assign op_a = fwd_a_d ? alu_out_m : rd1;
  assign op_b = fwd_b_d ? alu_out_m : rd2;

  always_comb begin
    dec          = '0;
    illegal      = 1'b0;
    nop          = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_jal       = 1'b0;
    is_jr        = 1'b0;
    dec.rs       = rs;
    dec.rt       = rt;
    dec.rd       = RAW'(instr_d[15:11]);
    dec.rd1      = rd1;
    dec.rd2      = rd2;
    dec.imm      = imm;
    dec.pc_plus4 = pc_plus4_d;
`ifdef ID_SHIFT_EN
    dec.shamt    = instr_d[10:6];
`endif
    case (instr_d[31:26])
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (instr_d[5:0])
          FN_ADD: dec.alu_ctrl = ALU_ADD;
          FN_SUB: dec.alu_ctrl = ALU_SUB;
          FN_AND: dec.alu_ctrl = ALU_AND;
          FN_OR:  dec.alu_ctrl = ALU_OR;
          FN_SLT: dec.alu_ctrl = ALU_SLT;
          FN_JR: begin
            is_jr         = 1'b1;
            dec.reg_write = 1'b0;
            dec.reg_dst   = 1'b0;
          end
`ifdef ID_SHIFT_EN
          FN_SLL: dec.alu_ctrl = ALU_SLL;
          FN_SRL: dec.alu_ctrl = ALU_SRL;
`else
          // The all-zero word is a NOP: bubble without raising illegal.
          FN_SLL, FN_SRL: begin
            nop     = (instr_d == '0);
            illegal = (instr_d != '0);
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_BEQ: begin is_beq = 1'b1; dec.alu_ctrl = ALU_SUB; end
      OP_BNE: begin is_bne = 1'b1; dec.alu_ctrl = ALU_SUB; end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_JAL: begin
        is_jal        = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.link      = 1'b1;
        dec.rd        = RAW'(5'd31);
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    pc_src_d    = 1'b0;
    pc_branch_d = pc_plus4_d + (imm << 2);
    if (is_jal)     pc_branch_d = {pc_plus4_d[XLEN-1:28], instr_d[25:0], 2'b00};
    else if (is_jr) pc_branch_d = op_a;
    if (!stall_d && !flush_e)
      pc_src_d = is_jal | is_jr | (is_beq && op_a == op_b) | (is_bne && op_a != op_b);
  end

  // Once halted every slot is a plain bubble; illegal_e only flags live illegal words.
  always_comb begin
    ex_d = dec;
    if (stall_d || flush_e || halt_q || nop || illegal) begin
      ex_d         = '0;
      ex_d.illegal = illegal && !stall_d && !flush_e && !halt_q;
    end
  end

  always_comb begin
    hcnt_d = '0;
    if (instr_d == '1) hcnt_d = (hcnt_q == HCW'(HALT_CNT)) ? hcnt_q : hcnt_q + HCW'(1);
    halt_d = halt_q | (hcnt_d == HCW'(HALT_CNT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q   <= '0;
      hcnt_q <= '0;
      halt_q <= 1'b0;
      rf_q   <= '{default: '0};
    end else begin
      ex_q   <= ex_d;
      hcnt_q <= hcnt_d;
      halt_q <= halt_d;
      if (reg_write_w && write_reg_w != '0) rf_q[write_reg_w] <= result_w;
    end
  end

  assign reg_write_e  = ex_q.reg_write;
  assign mem_to_reg_e = ex_q.mem_to_reg;
  assign mem_write_e  = ex_q.mem_write;
  assign alu_src_e    = ex_q.alu_src;
  assign reg_dst_e    = ex_q.reg_dst;
  assign link_e       = ex_q.link;
  assign alu_ctrl_e   = ex_q.alu_ctrl;
  assign rs_e         = ex_q.rs;
  assign rt_e         = ex_q.rt;
  assign rd_e         = ex_q.rd;
  assign shamt_e      = ex_q.shamt;
  assign rd1_e        = ex_q.rd1;
  assign rd2_e        = ex_q.rd2;
  assign imm_e        = ex_q.imm;
  assign pc_plus4_e   = ex_q.pc_plus4;
  assign illegal_e    = ex_q.illegal;
  assign halt_o       = halt_q;

endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: instruction-level reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_id_stage_p;
  localparam int XLEN = 32, NREG = 32, HALT_CNT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_d, flush_e, fwd_a_d, fwd_b_d, reg_write_w;
  logic [31:0] instr_d, pc_plus4_d, alu_out_m, result_w;
  logic [4:0]  write_reg_w;
  logic        pc_src_d, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
  logic        link_e, illegal_e, halt_o;
  logic [31:0] pc_branch_d, rd1_e, rd2_e, imm_e, pc_plus4_e;
  logic [2:0]  alu_ctrl_e;
  logic [4:0]  rs_e, rt_e, rd_e, shamt_e;

  id_stage_p #(.XLEN(XLEN), .NREG(NREG), .HALT_CNT(HALT_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
    .stall_d(stall_d), .flush_e(flush_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .alu_out_m(alu_out_m), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
    .result_w(result_w), .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e), .link_e(link_e), .alu_ctrl_e(alu_ctrl_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .shamt_e(shamt_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .pc_plus4_e(pc_plus4_e), .illegal_e(illegal_e), .halt_o(halt_o)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic rw, m2r, mw, asrc, rdst, link, ill;
    logic [2:0] alu;
    logic [4:0] rs, rt, rd, shamt;
    logic [31:0] rd1, rd2, imm, pc4;
  } ex_t;

  logic [31:0] m_rf [32];
  logic        m_halt;
  int          m_cnt;
  ex_t         m_e;

  // {legal, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, link, alu_ctrl}
  function automatic logic [9:0] ctl_of(input logic [31:0] ins);
    logic [9:0] c;
    c = '0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: c = 10'b1_100010_010;
        6'h22: c = 10'b1_100010_110;
        6'h24: c = 10'b1_100010_000;
        6'h25: c = 10'b1_100010_001;
        6'h2A: c = 10'b1_100010_111;
        6'h08: c = 10'b1_000000_000;
`ifdef ID_SHIFT_EN
        6'h00: c = 10'b1_100010_100;
        6'h02: c = 10'b1_100010_101;
`endif
        default: c = '0;
      endcase
      6'h04, 6'h05: c = 10'b1_000000_110;
      6'h08: c = 10'b1_100100_010;
      6'h23: c = 10'b1_110100_010;
      6'h2B: c = 10'b1_001100_010;
      6'h03: c = 10'b1_100011_000;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] rd_rf(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reg_write_w && write_reg_w == a) return result_w;
    return m_rf[a];
  endfunction

  initial begin : compare
    ex_t nx;
    logic [31:0] a, b, exp_br, wd;
    logic [9:0] c;
    logic [5:0] op;
    logic exp_src, nh, do_rst, do_wr;
    logic [4:0] wr;
    int nc;
    m_rf = '{default: 32'd0};
    m_halt = 1'b0;
    m_cnt = 0;
    m_e = '{default: 0};
    forever begin
      @(negedge clk);
      chk("m_reg_write_e", reg_write_e, m_e.rw);
      chk("m_mem_to_reg_e", mem_to_reg_e, m_e.m2r);
      chk("m_mem_write_e", mem_write_e, m_e.mw);
      chk("m_alu_src_e", alu_src_e, m_e.asrc);
      chk("m_reg_dst_e", reg_dst_e, m_e.rdst);
      chk("m_link_e", link_e, m_e.link);
      chk("m_alu_ctrl_e", alu_ctrl_e, m_e.alu);
      chk("m_rs_e", rs_e, m_e.rs);
      chk("m_rt_e", rt_e, m_e.rt);
      chk("m_rd_e", rd_e, m_e.rd);
      chk("m_shamt_e", shamt_e, m_e.shamt);
      chk("m_rd1_e", rd1_e, m_e.rd1);
      chk("m_rd2_e", rd2_e, m_e.rd2);
      chk("m_imm_e", imm_e, m_e.imm);
      chk("m_pc_plus4_e", pc_plus4_e, m_e.pc4);
      chk("m_illegal_e", illegal_e, m_e.ill);
      chk("m_halt_o", halt_o, m_halt);

      op = instr_d[31:26];
      a = fwd_a_d ? alu_out_m : rd_rf(instr_d[25:21]);
      b = fwd_b_d ? alu_out_m : rd_rf(instr_d[20:16]);
      exp_src = 1'b0;
      exp_br = pc_plus4_d + 32'($signed(instr_d[15:0])) * 32'd4;
      if (op == 6'h03) begin
        exp_src = 1'b1;
        exp_br = {pc_plus4_d[31:28], instr_d[25:0], 2'b00};
      end else if (op == 6'h00 && instr_d[5:0] == 6'h08) begin
        exp_src = 1'b1;
        exp_br = a;
      end else if (op == 6'h04) exp_src = (a == b);
      else if (op == 6'h05) exp_src = (a != b);
      if (stall_d || flush_e) exp_src = 1'b0;
      chk("m_pc_src_d", pc_src_d, exp_src);
      if (exp_src) chk("m_pc_branch_d", pc_branch_d, exp_br);

      nx = '{default: 0};
      c = ctl_of(instr_d);
      if (rst_n && !stall_d && !flush_e && !m_halt && c[9]) begin
        {nx.rw, nx.m2r, nx.mw, nx.asrc, nx.rdst, nx.link} = c[8:3];
        nx.alu = c[2:0];
        nx.rs  = instr_d[25:21];
        nx.rt  = instr_d[20:16];
        nx.rd  = (op == 6'h03) ? 5'd31 : instr_d[15:11];
`ifdef ID_SHIFT_EN
        nx.shamt = instr_d[10:6];
`endif
        nx.rd1 = rd_rf(instr_d[25:21]);
        nx.rd2 = rd_rf(instr_d[20:16]);
        nx.imm = 32'($signed(instr_d[15:0]));
        nx.pc4 = pc_plus4_d;
      end else if (rst_n) begin
        nx.ill = !c[9] && instr_d != 32'd0 && !stall_d && !flush_e && !m_halt;
      end
      nc = (instr_d == 32'hFFFF_FFFF) ? ((m_cnt < HALT_CNT) ? m_cnt + 1 : m_cnt) : 0;
      nh = m_halt || (nc >= HALT_CNT);
      do_rst = !rst_n;
      do_wr = reg_write_w;
      wr = write_reg_w;
      wd = result_w;

      @(posedge clk);
      if (do_rst) begin
        m_e = '{default: 0};
        m_halt = 1'b0;
        m_cnt = 0;
        m_rf = '{default: 32'd0};
      end else begin
        m_e = nx;
        m_halt = nh;
        m_cnt = nc;
        if (do_wr && wr != 5'd0) m_rf[wr] = wd;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set(input logic [31:0] ins, input logic [31:0] pc4);
    instr_d = ins; pc_plus4_d = pc4; stall_d = 1'b0; flush_e = 1'b0;
    fwd_a_d = 1'b0; fwd_b_d = 1'b0; alu_out_m = 32'd0;
    reg_write_w = 1'b0; write_reg_w = 5'd0; result_w = 32'd0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    reg_write_w = 1'b1; write_reg_w = r; result_w = d;
  endtask

  task automatic rand_in();
    instr_d = $urandom; pc_plus4_d = $urandom; stall_d = 1'($urandom);
    flush_e = 1'($urandom); fwd_a_d = 1'($urandom); fwd_b_d = 1'($urandom);
    alu_out_m = $urandom; reg_write_w = 1'b1; write_reg_w = 5'($urandom);
    result_w = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] ADD_R3_R5_R5 = 32'h00A5_1820;
  logic [31:0] misc [10] = '{32'h8C26_0004, 32'hAC26_0008, 32'h0022_3822, 32'h0022_3824,
                             32'h0022_3825, 32'h0022_382A, 32'h0002_38C0, 32'h0002_38C2,
                             32'h0000_0000, 32'h2004_0005};

  initial begin : stim
    rst_n = 1'b0;
    rand_in(); tick();
    rand_in(); tick();
    chk("rst_reg_write_e", reg_write_e, 1'b0);
    chk("rst_rd1_e", rd1_e, 32'd0);
    chk("rst_pc_plus4_e", pc_plus4_e, 32'd0);
    chk("rst_illegal_e", illegal_e, 1'b0);
    chk("rst_halt_o", halt_o, 1'b0);

    rst_n = 1'b1;
    set(ADD_R3_R5_R5, 32'h10); tick();
    chk("rf5_after_reset", rd1_e, 32'd0);
    set(ADD_R3_R5_R5, 32'h14); wb(5'd5, 32'h1234); tick();
    chk("bypass_rd1", rd1_e, 32'h1234);
    chk("bypass_rd2", rd2_e, 32'h1234);
    chk("bypass_alu", alu_ctrl_e, 3'b010);
    chk("bypass_rd", rd_e, 5'd3);
    set(32'h0, 32'h18); wb(5'd1, 32'd7); tick();
    set(32'h0, 32'h1C); wb(5'd2, 32'd9); tick();

    set(32'h1022_FFFE, 32'h100); fwd_a_d = 1'b1; alu_out_m = 32'd9;
    #1 chk("beq_src", pc_src_d, 1'b1);
    chk("beq_target", pc_branch_d, 32'hF8);
    tick();
    stall_d = 1'b1;
    #1 chk("beq_stall_src", pc_src_d, 1'b0);
    tick();
    chk("stall_bubble_rs", rs_e, 5'd0);
    chk("stall_bubble_imm", imm_e, 32'd0);

    set(32'h0C00_0040, 32'h204);
    #1 chk("jal_target", pc_branch_d, 32'h100);
    tick();
    chk("jal_link", link_e, 1'b1);
    chk("jal_rd", rd_e, 5'd31);
    chk("jal_pc4", pc_plus4_e, 32'h204);

    set(32'h2004_0005, 32'h300); flush_e = 1'b1; tick();
    chk("flush_rw", reg_write_e, 1'b0);
    chk("flush_imm", imm_e, 32'd0);
    flush_e = 1'b0; tick();
    chk("addi_imm", imm_e, 32'd5);
    chk("addi_rt", rt_e, 5'd4);
    set(32'hFC00_0000, 32'h304); tick();
    chk("illegal_op", illegal_e, 1'b1);
    stall_d = 1'b1; tick();
    chk("illegal_stalled", illegal_e, 1'b0);

    set(32'h1422_0003, 32'h200);
    #1 chk("bne_target", pc_branch_d, 32'h20C);
    tick();
    fwd_b_d = 1'b1; alu_out_m = 32'd7;
    #1 chk("bne_not_taken", pc_src_d, 1'b0);
    tick();
    set(32'h0040_0008, 32'h208);
    #1 chk("jr_target", pc_branch_d, 32'd9);
    tick();
    fwd_a_d = 1'b1; alu_out_m = 32'h55;
    #1 chk("jr_fwd_target", pc_branch_d, 32'h55);
    tick();
    flush_e = 1'b1;
    #1 chk("jr_flush_src", pc_src_d, 1'b0);
    tick();
    set(32'h1000_FFFC, 32'h4);
    #1 chk("beq_wrap", pc_branch_d, 32'hFFFF_FFF4);
    tick();
    set(32'h0000_5020, 32'h40); wb(5'd0, 32'hDEAD); tick();
    chk("r0_bypass", rd1_e, 32'd0);
    set(ADD_R3_R5_R5, 32'h44); stall_d = 1'b1; flush_e = 1'b1; wb(5'd9, 32'hAB); tick();
    chk("stall_flush_bubble", reg_write_e, 1'b0);
    set(32'h0120_0008, 32'h48);
    #1 chk("wb_during_stall", pc_branch_d, 32'hAB);
    tick();
    for (int i = 0; i < 10; i++) begin
      set(misc[i], 32'h80 + 32'(i) * 4); wb(5'(i + 6), 32'(i) * 32'h111); tick();
    end

    for (int i = 0; i < 4; i++) begin
      set(32'hFFFF_FFFF, 32'h400); tick();
      chk("halt_low_a", halt_o, 1'b0);
    end
    set(32'h0, 32'h404); tick();
    for (int i = 0; i < 5; i++) begin
      set(32'hFFFF_FFFF, 32'h408); tick();
      chk("halt_seq", halt_o, (i == 4) ? 1'b1 : 1'b0);
    end
    set(ADD_R3_R5_R5, 32'h40C); wb(5'd8, 32'h77); tick();
    chk("halt_hold", halt_o, 1'b1);
    chk("halt_bubble", reg_write_e, 1'b0);
    set(32'h0, 32'h410); tick();

    rst_n = 1'b0; rand_in(); tick();
    chk("rst_clears_halt", halt_o, 1'b0);
    rst_n = 1'b1;
    set(32'h0108_1820, 32'h500); tick();
    chk("rst_clears_rf", rd1_e, 32'd0);
    chk("post_rst_decode", reg_write_e, 1'b1);
    set(32'h0, 32'h504); tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
